// File: rtl/userio_pkg.sv
// Shared types and helpers for the USERIO pattern sequencer.
package userio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Table entries are packed as {hold, pwdriven, data} with data in the LSBs.
  localparam int DATA_LSB = 0;

  function automatic int pwd_lsb(input int width);
    return width;
  endfunction

  function automatic int hold_lsb(input int width);
    return 2 * width;
  endfunction

  // Address width for a table of the given depth (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/userio_sync.sv
// N-bit two-flop synchronizer for asynchronous pad readback.
module userio_sync
  import userio_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta_r;
  logic [N-1:0] sync_r;

  // Two back-to-back flops to settle metastability before use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {N{1'b0}};
      sync_r <= {N{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/userio_seq.sv
// Pattern sequencer in front of the USERIO pad block: plays a table of
// (data, drive-enable, hold) steps, captures readback at each step end and
// passes manual drive values through while idle.
module userio_seq
  import userio_pkg::*;
#(
  parameter int pWIDTH      = 8,
  parameter int pDEPTH      = 16,
  parameter int pHOLD_WIDTH = 16,
  parameter int pREP_WIDTH  = 8
) (
  input  logic                            usb_clk,
  input  logic                            reset_n,
  input  logic                            I_wr_en,
  input  logic [addr_width(pDEPTH)-1:0]   I_wr_addr,
  input  logic [2*pWIDTH+pHOLD_WIDTH-1:0] I_wr_data,
  input  logic [addr_width(pDEPTH):0]     I_num_steps,
  input  logic [pREP_WIDTH-1:0]           I_repeat,
  input  logic                            I_start,
  input  logic                            I_stop,
  input  logic [pWIDTH-1:0]               I_manual_data,
  input  logic [pWIDTH-1:0]               I_manual_pwdriven,
  input  logic [pWIDTH-1:0]               I_userio_in,
  output logic [pWIDTH-1:0]               O_userio_drive_data,
  output logic [pWIDTH-1:0]               O_userio_pwdriven,
  output logic                            O_busy,
  output logic                            O_done,
  output logic [addr_width(pDEPTH)-1:0]   O_step,
  output logic [pWIDTH-1:0]               O_capture,
  output logic                            O_capture_valid,
  output logic                            O_wr_err
);

  localparam int AW       = addr_width(pDEPTH);
  localparam int EW       = 2 * pWIDTH + pHOLD_WIDTH;
  localparam int PWD_LSB  = pwd_lsb(pWIDTH);
  localparam int HOLD_LSB = hold_lsb(pWIDTH);
  localparam logic [AW:0] MAX_STEPS = (AW + 1)'(pDEPTH);

  logic [EW-1:0]          pat_mem_r [pDEPTH];

  seq_state_e             state_r, state_nxt_s;
  logic [AW-1:0]          step_r, step_nxt_s;
  logic [pHOLD_WIDTH-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic [pREP_WIDTH-1:0]  pass_r, pass_nxt_s, pass_inc_s;
  logic [AW:0]            num_steps_r, num_steps_nxt_s;
  logic [pREP_WIDTH-1:0]  repeat_r, repeat_nxt_s;

  logic                   start_ok_s, last_cycle_s, last_step_s;
  logic                   cap_en_s, done_nxt_s;
  logic [pWIDTH-1:0]      drive_data_nxt_s, drive_pwd_nxt_s;
  logic [pWIDTH-1:0]      userio_sync_s;

  logic [pWIDTH-1:0]      drive_data_r, drive_pwd_r, capture_r;
  logic                   busy_r, done_r, cap_valid_r, wr_err_r;

  userio_sync #(.N(pWIDTH)) u_sync (
    .clk   (usb_clk),
    .rst_n (reset_n),
    .d     (I_userio_in),
    .q     (userio_sync_s)
  );

  // Pattern table: writable only while idle, contents survive reset
  always_ff @(posedge usb_clk) begin
    if (I_wr_en && (state_r == ST_IDLE)) begin
      pat_mem_r[I_wr_addr] <= I_wr_data;
    end
  end

  assign start_ok_s   = (I_num_steps != (AW + 1)'(0)) && (I_num_steps <= MAX_STEPS);
  assign last_cycle_s = (hold_cnt_r == pat_mem_r[step_r][HOLD_LSB +: pHOLD_WIDTH]);
  assign last_step_s  = ({1'b0, step_r} == (num_steps_r - (AW + 1)'(1)));
  assign pass_inc_s   = pass_r + pREP_WIDTH'(1);

  // Sequencer next state, step/hold/pass counters and capture strobe
  always_comb begin
    state_nxt_s     = state_r;
    step_nxt_s      = step_r;
    hold_cnt_nxt_s  = hold_cnt_r;
    pass_nxt_s      = pass_r;
    num_steps_nxt_s = num_steps_r;
    repeat_nxt_s    = repeat_r;
    cap_en_s        = 1'b0;
    done_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Stop in the same cycle cancels the start
        if (I_start && !I_stop && start_ok_s) begin
          state_nxt_s     = ST_RUN;
          num_steps_nxt_s = I_num_steps;
          repeat_nxt_s    = I_repeat;
          step_nxt_s      = AW'(0);
          hold_cnt_nxt_s  = pHOLD_WIDTH'(0);
          pass_nxt_s      = pREP_WIDTH'(0);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (I_stop) begin
          // Abort truncates the current step without a capture
          state_nxt_s    = ST_DONE;
          done_nxt_s     = 1'b1;
          step_nxt_s     = AW'(0);
          hold_cnt_nxt_s = pHOLD_WIDTH'(0);
        end else if (last_cycle_s) begin
          cap_en_s       = 1'b1;
          hold_cnt_nxt_s = pHOLD_WIDTH'(0);
          if (last_step_s) begin
            step_nxt_s = AW'(0);
            pass_nxt_s = pass_inc_s;
            // Repeat 0 runs forever; nonzero never wraps before matching
            if ((repeat_r != pREP_WIDTH'(0)) && (pass_inc_s == repeat_r)) begin
              state_nxt_s = ST_DONE;
              done_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            step_nxt_s = step_r + AW'(1);
          end
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + pHOLD_WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        step_nxt_s  = AW'(0);
      end
    endcase
  end

  // Next pad drive: table entry of the upcoming step while running, else manual
  always_comb begin
    drive_data_nxt_s = I_manual_data;
    drive_pwd_nxt_s  = I_manual_pwdriven;
    if (state_nxt_s == ST_RUN) begin
      drive_data_nxt_s = pat_mem_r[step_nxt_s][DATA_LSB +: pWIDTH];
      drive_pwd_nxt_s  = pat_mem_r[step_nxt_s][PWD_LSB +: pWIDTH];
    end else begin
      drive_data_nxt_s = I_manual_data;
      drive_pwd_nxt_s  = I_manual_pwdriven;
    end
  end

  // State, counters and all registered outputs; reset tri-states every pin
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      step_r       <= AW'(0);
      hold_cnt_r   <= pHOLD_WIDTH'(0);
      pass_r       <= pREP_WIDTH'(0);
      num_steps_r  <= (AW + 1)'(0);
      repeat_r     <= pREP_WIDTH'(0);
      drive_data_r <= pWIDTH'(0);
      drive_pwd_r  <= pWIDTH'(0);
      capture_r    <= pWIDTH'(0);
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cap_valid_r  <= 1'b0;
      wr_err_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      step_r       <= step_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
      pass_r       <= pass_nxt_s;
      num_steps_r  <= num_steps_nxt_s;
      repeat_r     <= repeat_nxt_s;
      drive_data_r <= drive_data_nxt_s;
      drive_pwd_r  <= drive_pwd_nxt_s;
      busy_r       <= (state_nxt_s == ST_RUN);
      done_r       <= done_nxt_s;
      cap_valid_r  <= cap_en_s;
      wr_err_r     <= I_wr_en && (state_r != ST_IDLE);
      if (cap_en_s) begin
        capture_r <= userio_sync_s;
      end else begin
        capture_r <= capture_r;
      end
    end
  end

  assign O_userio_drive_data = drive_data_r;
  assign O_userio_pwdriven   = drive_pwd_r;
  assign O_busy              = busy_r;
  assign O_done              = done_r;
  assign O_step              = step_r;
  assign O_capture           = capture_r;
  assign O_capture_valid     = cap_valid_r;
  assign O_wr_err            = wr_err_r;

endmodule

// File: tb/tb_userio_seq.sv
// Randomized self-checking bench for userio_seq against a step-stream model.
module tb_userio_seq;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int HW = 16;
  localparam int RW = 8;
  localparam int AW = 4;

  logic            usb_clk = 1'b0;
  logic            reset_n;
  logic            I_wr_en;
  logic [AW-1:0]   I_wr_addr;
  logic [2*W+HW-1:0] I_wr_data;
  logic [AW:0]     I_num_steps;
  logic [RW-1:0]   I_repeat;
  logic            I_start, I_stop;
  logic [W-1:0]    I_manual_data, I_manual_pwdriven, I_userio_in;
  logic [W-1:0]    O_userio_drive_data, O_userio_pwdriven, O_capture;
  logic            O_busy, O_done, O_capture_valid, O_wr_err;
  logic [AW-1:0]   O_step;

  // Reference table contents as written by the bench
  logic [W-1:0]  m_data [D];
  logic [W-1:0]  m_pwd  [D];
  logic [HW-1:0] m_hold [D];

  int n_vec = 0;
  int n_err = 0;

  always #5 usb_clk = ~usb_clk;

  userio_seq dut (
    .usb_clk             (usb_clk),
    .reset_n             (reset_n),
    .I_wr_en             (I_wr_en),
    .I_wr_addr           (I_wr_addr),
    .I_wr_data           (I_wr_data),
    .I_num_steps         (I_num_steps),
    .I_repeat            (I_repeat),
    .I_start             (I_start),
    .I_stop              (I_stop),
    .I_manual_data       (I_manual_data),
    .I_manual_pwdriven   (I_manual_pwdriven),
    .I_userio_in         (I_userio_in),
    .O_userio_drive_data (O_userio_drive_data),
    .O_userio_pwdriven   (O_userio_pwdriven),
    .O_busy              (O_busy),
    .O_done              (O_done),
    .O_step              (O_step),
    .O_capture           (O_capture),
    .O_capture_valid     (O_capture_valid),
    .O_wr_err            (O_wr_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk);
    @(negedge usb_clk);
  endtask

  task automatic write_entry(input int a, input logic [W-1:0] d, input logic [W-1:0] p,
                             input logic [HW-1:0] h);
    I_wr_en   = 1'b1;
    I_wr_addr = AW'(a);
    I_wr_data = {h, p, d};
    m_data[a] = d;
    m_pwd[a]  = p;
    m_hold[a] = h;
    tick();
    I_wr_en = 1'b0;
  endtask

  // Play one sequence and compare every cycle against the expanded step stream.
  // stop_at: iteration at which stop is applied (-1 none); wr_at: iteration of a
  // dropped write (-1 none); fixed_in: constant readback value (-1 random).
  task automatic run_seq(input int n, input int rep, input int stop_at, input int wr_at,
                         input int fixed_in);
    int   flat_step[$];
    bit   flat_last[$];
    logic [W-1:0] in_hist[$];
    logic [W-1:0] md_hist[$];
    logic [W-1:0] mp_hist[$];
    logic [W-1:0] v;
    int   passes, lrun, exp_caps, got_caps, s_idx;
    bit   stopped, exp_busy, exp_valid;

    passes = 0;
    while (1'b1) begin
      for (int s = 0; s < n; s++) begin
        for (int h = 0; h <= int'(m_hold[s]); h++) begin
          flat_step.push_back(s);
          flat_last.push_back(h == int'(m_hold[s]));
        end
      end
      passes++;
      if (rep != 0 && passes == rep) break;
      if (rep == 0 && flat_step.size() > stop_at) break;
    end
    lrun = flat_step.size();
    stopped = 1'b0;
    if (stop_at >= 0 && stop_at < lrun) begin
      lrun = stop_at + 1;
      stopped = 1'b1;
    end

    // Readback held for two cycles before start so the synchronizer is primed
    v = (fixed_in >= 0) ? W'(fixed_in) : W'($urandom);
    I_userio_in       = v;
    I_manual_data     = W'($urandom);
    I_manual_pwdriven = W'($urandom);
    tick();
    for (int k = 0; k < 3; k++) begin
      in_hist.push_back(v);
      md_hist.push_back(I_manual_data);
      mp_hist.push_back(I_manual_pwdriven);
    end
    I_start     = 1'b1;
    I_num_steps = (AW + 1)'(n);
    I_repeat    = RW'(rep);
    tick();

    exp_caps = 0;
    got_caps = 0;
    for (int i = 0; i < lrun + 4; i++) begin
      exp_busy = (i < lrun);
      s_idx = exp_busy ? flat_step[i] : 0;
      check_eq("busy", 32'(O_busy), 32'(exp_busy));
      check_eq("step", 32'(O_step), 32'(s_idx));
      check_eq("done", 32'(O_done), 32'(i == lrun));
      check_eq("drive_data", 32'(O_userio_drive_data),
               32'(exp_busy ? m_data[s_idx] : md_hist[i + 2]));
      check_eq("pwdriven", 32'(O_userio_pwdriven),
               32'(exp_busy ? m_pwd[s_idx] : mp_hist[i + 2]));
      check_eq("wr_err", 32'(O_wr_err), 32'(wr_at >= 0 && i == wr_at + 1));
      exp_valid = (i >= 1) && (i - 1 < lrun) && flat_last[i - 1] &&
                  !(stopped && (i - 1 == stop_at));
      check_eq("cap_valid", 32'(O_capture_valid), 32'(exp_valid));
      if (exp_valid) begin
        exp_caps++;
        check_eq("capture", 32'(O_capture), 32'(in_hist[i]));
      end
      if (O_capture_valid) got_caps++;

      // Inputs for this cycle; start/num_steps/repeat noise must be ignored
      v = (fixed_in >= 0) ? W'(fixed_in) : W'($urandom);
      I_userio_in       = v;
      I_manual_data     = W'($urandom);
      I_manual_pwdriven = W'($urandom);
      in_hist.push_back(v);
      md_hist.push_back(I_manual_data);
      mp_hist.push_back(I_manual_pwdriven);
      I_start     = (i <= lrun) ? 1'($urandom) : 1'b0;
      I_num_steps = (AW + 1)'($urandom);
      I_repeat    = RW'($urandom);
      I_stop      = stopped && (i == stop_at);
      I_wr_en     = (i == wr_at);
      I_wr_addr   = AW'($urandom);
      I_wr_data   = (2 * W + HW)'($urandom);
      tick();
    end
    I_start = 1'b0;
    I_stop  = 1'b0;
    I_wr_en = 1'b0;
    check_eq("cap_count", 32'(got_caps), 32'(exp_caps));
  endtask

  // Start requests that must leave the sequencer idle
  task automatic bad_start(input int n, input bit with_stop);
    I_start     = 1'b1;
    I_stop      = with_stop;
    I_num_steps = (AW + 1)'(n);
    I_repeat    = RW'(1);
    tick();
    I_start = 1'b0;
    I_stop  = 1'b0;
    check_eq("bad_start_busy", 32'(O_busy), 32'(0));
    tick();
    check_eq("bad_start_busy2", 32'(O_busy), 32'(0));
    check_eq("bad_start_done", 32'(O_done), 32'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    I_wr_en = 1'b0; I_wr_addr = '0; I_wr_data = '0;
    I_num_steps = '0; I_repeat = '0; I_start = 1'b0; I_stop = 1'b0;
    I_manual_data = 8'h3C; I_manual_pwdriven = 8'hFF; I_userio_in = 8'h00;
    @(negedge usb_clk);

    // Reset: pins tri-stated, then manual values one cycle after release
    tick();
    check_eq("rst_pwd", 32'(O_userio_pwdriven), 32'h0);
    check_eq("rst_data", 32'(O_userio_drive_data), 32'h0);
    check_eq("rst_busy", 32'(O_busy), 32'h0);
    check_eq("rst_done", 32'(O_done), 32'h0);
    check_eq("rst_capv", 32'(O_capture_valid), 32'h0);
    reset_n = 1'b1;
    tick();
    check_eq("man_pwd", 32'(O_userio_pwdriven), 32'hFF);
    check_eq("man_data", 32'(O_userio_drive_data), 32'h3C);
    I_manual_data = 8'h5A; I_manual_pwdriven = 8'h0F;
    tick();
    check_eq("man_pwd2", 32'(O_userio_pwdriven), 32'h0F);
    check_eq("man_data2", 32'(O_userio_drive_data), 32'h5A);

    // Three-step table with holds {0,2,1}, two passes
    write_entry(0, 8'h11, 8'hF0, 16'd0);
    write_entry(1, 8'h22, 8'h0F, 16'd2);
    write_entry(2, 8'h33, 8'hAA, 16'd1);
    check_eq("idle_wr_err", 32'(O_wr_err), 32'h0);
    run_seq(3, 2, -1, -1, -1);

    // Constant readback through a 4-cycle step
    write_entry(1, 8'h44, 8'hCC, 16'd3);
    run_seq(3, 1, -1, -1, 8'hA5);

    // Infinite repeat aborted after 40 cycles
    run_seq(3, 0, 40, -1, -1);

    // Write during run is dropped; the following run proves the table intact
    run_seq(3, 2, -1, 4, -1);
    run_seq(3, 1, -1, -1, -1);

    // Ignored starts
    bad_start(0, 1'b0);
    bad_start(17, 1'b0);
    bad_start(2, 1'b1);

    // Randomized tables and runs
    for (int r = 0; r < 6; r++) begin
      int n, rep, st;
      for (int a = 0; a < D; a++) begin
        write_entry(a, W'($urandom), W'($urandom), HW'($urandom_range(0, 3)));
      end
      n   = $urandom_range(1, D);
      rep = $urandom_range(0, 3);
      st  = (rep == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : -1;
      run_seq(n, rep, st, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : -1, -1);
    end

    // Reset in the middle of a run: immediate tri-state, no done pulse
    I_manual_pwdriven = 8'hFF;
    I_start = 1'b1; I_num_steps = 5'd3; I_repeat = 8'd0;
    tick();
    I_start = 1'b0;
    tick(); tick(); tick();
    check_eq("pre_rst_busy", 32'(O_busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_pwd", 32'(O_userio_pwdriven), 32'h0);
    check_eq("midrst_busy", 32'(O_busy), 32'h0);
    check_eq("midrst_step", 32'(O_step), 32'h0);
    @(negedge usb_clk);
    tick();
    check_eq("midrst_done", 32'(O_done), 32'h0);
    check_eq("midrst_pwd2", 32'(O_userio_pwdriven), 32'h0);
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_pwd", 32'(O_userio_pwdriven), 32'hFF);
    check_eq("post_rst_done", 32'(O_done), 32'h0);
    check_eq("post_rst_busy", 32'(O_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
